// File: rtl/led7seg_scan_if.sv
// Bundle between the game scoring logic / display driver (master) and the
// 7-segment scan controller (slave).
//   load       master -> slave  request to convert and show bin_in
//   bin_in     master -> slave  unsigned binary value, BIN_W bits
//   busy       slave -> master  conversion in flight
//   digit_bcd  slave -> master  BCD code of the lit digit, to the shared decoder
//   digit_sel  slave -> master  active-low anode enables, bit 0 = units
interface led7seg_scan_if #(
    parameter int BIN_W      = 9,
    parameter int NUM_DIGITS = 3
);
    logic                  load;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic [3:0]            digit_bcd;
    logic [NUM_DIGITS-1:0] digit_sel;

    modport master (
        output load,
        output bin_in,
        input  busy,
        input  digit_bcd,
        input  digit_sel
    );

    modport slave (
        input  load,
        input  bin_in,
        output busy,
        output digit_bcd,
        output digit_sel
    );
endinterface

// File: rtl/led7seg_scan_ctrl.sv
// Multi-digit common-anode 7-segment scan controller with one shared
// BCD-to-segment decoder. A binary score is converted to BCD by a sequential
// shift-add-3 engine, committed atomically to the display registers, and the
// digits are time-multiplexed onto digit_bcd/digit_sel with leading-zero
// blanking done on the anodes.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  led7seg_scan_if slave: load, bin_in in; busy, digit_bcd, digit_sel out
// BIN_W and NUM_DIGITS must match the parameters of the connected interface.
module led7seg_scan_ctrl #(
    parameter int CLK_DIV    = 50000,
    parameter int BIN_W      = 9,
    parameter int NUM_DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst,
    led7seg_scan_if.slave bus
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int PS_W  = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  accept, shift_en, commit_en;
    logic [CNT_W-1:0]      bit_cnt;
    logic [BIN_W-1:0]      bin_sh;
    logic [BCD_W-1:0]      bcd_work, bcd_adj, disp;
    logic [PS_W-1:0]       ps;
    logic [IDX_W-1:0]      idx;
    logic [NUM_DIGITS-1:0] blank;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic [3:0]            digit_bcd_r;
    logic [NUM_DIGITS-1:0] digit_sel_r;

    // Double-dabble correction: every nibble >= 5 gets +3 so the following
    // left shift carries into the next decade instead of producing A..F.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign bcd_adj = add3(bcd_work);

    // Conversion FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Conversion FSM: next state and strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        shift_en  = 1'b0;
        commit_en = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt == '0)
                    state_nxt = COMMIT;
            end
            COMMIT: begin
                commit_en = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

    // Shift-add-3 engine and atomic commit to the display registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            bin_sh   <= '0;
            bcd_work <= '0;
            disp     <= '0;
        end else begin
            if (accept) begin
                bin_sh   <= bus.bin_in;
                bcd_work <= '0;
                bit_cnt  <= CNT_W'(BIN_W - 1);
            end else if (shift_en) begin
                {bcd_work, bin_sh} <= {bcd_adj[BCD_W-2:0], bin_sh, 1'b0};
                bit_cnt            <= bit_cnt - CNT_W'(1);
            end
            // Display only ever changes here, so a scan slot never sees a
            // half-converted value.
            if (commit_en)
                disp <= bcd_work;
        end
    end

    // Free-running prescaler and scan index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps  <= '0;
            idx <= '0;
        end else if (ps == PS_W'(CLK_DIV - 1)) begin
            ps  <= '0;
            idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            ps <= ps + PS_W'(1);
        end
    end

    // Digit i > 0 is blank when it and every more significant digit are 0.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        blank    = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            all_zero = all_zero && (disp[4*i +: 4] == 4'd0);
            blank[i] = all_zero;
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = disp[4*i +: 4];
                cur_blank = blank[i];
            end
        end
    end

    // Registered outputs: anode and BCD always change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_bcd_r <= '0;
            digit_sel_r <= ~NUM_DIGITS'(1);
        end else if (cur_blank) begin
            digit_bcd_r <= '0;
            digit_sel_r <= '1;
        end else begin
            digit_bcd_r <= cur_nib;
            digit_sel_r <= ~(NUM_DIGITS'(1) << idx);
        end
    end

    assign bus.digit_bcd = digit_bcd_r;
    assign bus.digit_sel = digit_sel_r;

endmodule

// File: tb/tb_led7seg_scan_ctrl.sv
// Self-checking bench for led7seg_scan_ctrl (CLK_DIV=4, BIN_W=9, NUM_DIGITS=3).
// The reference model tracks the displayed value as an integer, the load
// acceptance time and the scan slot from the cycle count, and derives the
// expected digit/anode with decimal arithmetic.
module tb_led7seg_scan_ctrl;
    localparam int CLK_DIV = 4;
    localparam int BIN_W   = 9;
    localparam int ND      = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    led7seg_scan_if #(.BIN_W(BIN_W), .NUM_DIGITS(ND)) bus ();

    led7seg_scan_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .BIN_W     (BIN_W),
        .NUM_DIGITS(ND)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    int n_edge;      // rising edges since reset release
    bit have;        // a load has been accepted since reset
    int ta;          // edge at which the last load was accepted
    int pend;        // value latched by that load
    int disp_val;    // value held in the display registers
    int shown_val;   // value the digit outputs currently reflect
    int frame_dig[ND];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int p10(input int i);
        int r;
        r = 1;
        for (int k = 0; k < i; k++) r = r * 10;
        return r;
    endfunction

    task automatic check_outputs();
        int slot;
        bit blk;
        int exp_sel;
        int exp_bcd;
        slot    = (n_edge == 0) ? 0 : ((n_edge - 1) / CLK_DIV) % ND;
        blk     = (slot > 0) && (shown_val < p10(slot));
        exp_bcd = blk ? 0 : (shown_val / p10(slot)) % 10;
        exp_sel = blk ? 7 : (7 & ~(1 << slot));
        chk("busy", int'(bus.busy), (have && n_edge <= ta + BIN_W) ? 1 : 0);
        chk("digit_sel", int'(bus.digit_sel), exp_sel);
        chk("digit_bcd", int'(bus.digit_bcd), exp_bcd);
        chk("sel_one_low", ($countones(~bus.digit_sel) <= 1) ? 1 : 0, 1);
        for (int i = 0; i < ND; i++)
            if (bus.digit_sel[i] == 1'b0) frame_dig[i] = int'(bus.digit_bcd);
    endtask

    task automatic step();
        bit ld;
        int bi;
        ld = bus.load;
        bi = int'(bus.bin_in);
        @(posedge clk);
        n_edge++;
        shown_val = disp_val;
        if (have && n_edge == ta + BIN_W + 1) disp_val = pend;
        if (ld && (!have || n_edge >= ta + BIN_W + 2)) begin
            have = 1'b1;
            ta   = n_edge;
            pend = bi;
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int hold_cycles);
        rst = 1'b1;
        bus.load = 1'b0;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_sel", int'(bus.digit_sel), 6);
        chk("rst_bcd", int'(bus.digit_bcd), 0);
        repeat (hold_cycles) @(posedge clk);
        #2;
        rst       = 1'b0;
        n_edge    = 0;
        have      = 1'b0;
        ta        = 0;
        pend      = 0;
        disp_val  = 0;
        shown_val = 0;
        check_outputs();
    endtask

    task automatic issue(input int v);
        bus.bin_in = BIN_W'(v);
        bus.load   = 1'b1;
        step();
        bus.load   = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 40) begin
            step();
            k++;
        end
        chk("wait_idle_bound", int'(bus.busy), 0);
    endtask

    task automatic read_frame(output int val);
        step();
        for (int i = 0; i < ND; i++) frame_dig[i] = 0;
        repeat (ND * CLK_DIV) step();
        val = 0;
        for (int i = 0; i < ND; i++) val = val + frame_dig[i] * p10(i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int val;
        int bc;
        bus.load   = 1'b0;
        bus.bin_in = '0;
        #2;

        // Reset and idle scan showing "0"
        do_reset(2);
        repeat (12) step();

        // 300: busy length and frame contents
        issue(300);
        bc = 0;
        while (bus.busy && bc < 40) begin
            bc++;
            step();
        end
        chk("busy_len_300", bc, 10);
        read_frame(val);
        chk("frame_300", val, 300);

        // Leading-zero blanking vs. embedded zero
        issue(7);
        wait_idle();
        read_frame(val);
        chk("frame_7", val, 7);
        issue(105);
        wait_idle();
        read_frame(val);
        chk("frame_105", val, 105);

        // Load during conversion is ignored
        issue(300);
        step();
        step();
        issue(42);
        wait_idle();
        read_frame(val);
        chk("frame_ignore_42", val, 300);

        // Load on the cycle after busy falls is accepted
        issue(123);
        wait_idle();
        issue(45);
        chk("reload_accept", int'(bus.busy), 1);
        wait_idle();
        read_frame(val);
        chk("frame_45", val, 45);

        // Reset in the middle of SHIFT
        issue(256);
        repeat (4) step();
        do_reset(1);
        repeat (8) step();
        issue(77);
        wait_idle();
        read_frame(val);
        chk("frame_77_after_rst", val, 77);

        // Full sweep, with random ignored loads thrown in
        for (int v = 0; v < (1 << BIN_W); v++) begin
            issue(v);
            if ($urandom_range(0, 1) == 1) begin
                step();
                issue(int'($urandom_range(0, (1 << BIN_W) - 1)));
            end
            wait_idle();
            read_frame(val);
            chk("sweep_frame", val, v);
        end

        // Random load/bin_in traffic checked cycle by cycle
        for (int c = 0; c < 600; c++) begin
            bus.load   = ($urandom_range(0, 3) == 0);
            bus.bin_in = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
            step();
        end
        bus.load = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
